ps2_mouse_tx: RTL and testbench

PS2_MOUSE_TX -- requirements
Module: ps2_mouse_tx

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 48 ++++
 rtl/ps2_mouse_tx.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_mouse_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: controller
// state encoding, default timing constants and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RTS       = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4,
    ACK       = 3'd5,
    WAIT_IDLE = 3'd6
  } ps2_state_e;

  // 100 us clock inhibit at 50 MHz
  localparam int RTS_CYCLES_DEF     = 5000;
  // consecutive equal raw samples before a filtered line may change
  localparam int FILTER_LEN_DEF     = 8;
  // 20 ms per-wait limit at 50 MHz
  localparam int TIMEOUT_CYCLES_DEF = 1000000;
  // eight data bits followed by the parity bit
  localparam int FRAME_BITS         = 9;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Glitch filter for one PS/2 line. The filtered value only follows the raw
// input after FILTER_LEN consecutive samples that disagree with it; a
// one-cycle fall_tick marks each filtered 1->0 transition. The line is
// expected to be already synchronised to clk by the caller.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic filt,
  output logic fall_tick
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] cnt_r;
  logic          filt_r;
  logic          fall_r;

  // Count disagreeing samples; adopt the raw value once the run is long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      filt_r <= 1'b1;
      fall_r <= 1'b0;
    end else if (line_in != filt_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r  <= {CW{1'b0}};
        filt_r <= line_in;
        fall_r <= ~line_in;
      end else begin
        cnt_r  <= cnt_r + CW'(1);
        fall_r <= 1'b0;
      end
    end else begin
      cnt_r  <= {CW{1'b0}};
      fall_r <= 1'b0;
    end
  end

  assign filt      = filt_r;
  assign fall_tick = fall_r;

endmodule

// File: rtl/ps2_mouse_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the clock for
// RTS_CYCLES, issues the start bit, shifts eight data bits plus odd parity
// on device clock falls, releases the stop bit and checks the device ack.
// Optional feature macro: PS2_TX_WATCHDOG_EN adds a per-wait timeout that
// aborts a stalled transaction with tx_err_tick.
module ps2_mouse_tx
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam logic [31:0] RTS_LAST = 32'(RTS_CYCLES - 1);
  localparam logic [3:0]  BIT_LAST = 4'(FRAME_BITS - 1);

  ps2_state_e state_r, state_s;
  logic [8:0]  frame_r, frame_s;
  logic [3:0]  bit_idx_r, bit_idx_s;
  logic [31:0] rts_cnt_r, rts_cnt_s;
  logic        ps2c_oe_r, ps2c_oe_s;
  logic        ps2d_oe_r, ps2d_oe_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        err_r, err_s;

  logic c_filt_s, c_fall_s;
  logic d_filt_s, d_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .rst       (rst),
    .line_in   (ps2c_in),
    .filt      (c_filt_s),
    .fall_tick (c_fall_s)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk       (clk),
    .rst       (rst),
    .line_in   (ps2d_in),
    .filt      (d_filt_s),
    .fall_tick (d_fall_unused)
  );

`ifdef PS2_TX_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt_r, wd_cnt_s;
  logic        wd_watch_s;
  logic        wd_expire_s;
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

  // Next-state, frame bookkeeping and next values of the registered outputs.
  always_comb begin
    state_s   = state_r;
    frame_s   = frame_r;
    bit_idx_s = bit_idx_r;
    rts_cnt_s = rts_cnt_r;
    done_s    = 1'b0;
    err_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (wr_ps2) begin
          frame_s   = {odd_parity(din), din};
          rts_cnt_s = 32'd0;
          state_s   = RTS;
        end else begin
          state_s = IDLE;
        end
      end
      RTS: begin
        if (rts_cnt_r == RTS_LAST) begin
          state_s = START;
        end else begin
          rts_cnt_s = rts_cnt_r + 32'd1;
        end
      end
      START: begin
        if (c_fall_s) begin
          bit_idx_s = 4'd0;
          state_s   = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (c_fall_s) begin
          if (bit_idx_r == BIT_LAST) begin
            state_s = STOP;
          end else begin
            bit_idx_s = bit_idx_r + 4'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (c_fall_s) begin
          state_s = ACK;
        end else begin
          state_s = STOP;
        end
      end
      ACK: begin
        if (c_fall_s) begin
          if (!d_filt_s) begin
            state_s = WAIT_IDLE;
          end else begin
            err_s   = 1'b1;
            state_s = IDLE;
          end
        end else begin
          state_s = ACK;
        end
      end
      WAIT_IDLE: begin
        if (c_filt_s && d_filt_s) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WAIT_IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

`ifdef PS2_TX_WATCHDOG_EN
    // Only the waits on the device are watched; RTS is self-timed.
    wd_watch_s  = (state_r == START) || (state_r == DATA) || (state_r == STOP) ||
                  (state_r == ACK)   || (state_r == WAIT_IDLE);
    wd_expire_s = wd_watch_s && (state_s == state_r) && !c_fall_s && (wd_cnt_r == WD_LAST);
    if (wd_expire_s) begin
      err_s   = 1'b1;
      done_s  = 1'b0;
      state_s = IDLE;
    end else begin
      err_s = err_s;
    end
    if ((state_s != state_r) || c_fall_s || !wd_watch_s) begin
      wd_cnt_s = 32'd0;
    end else begin
      wd_cnt_s = wd_cnt_r + 32'd1;
    end
`endif

    // Outputs follow the state being entered so they line up with it.
    ps2c_oe_s = (state_s == RTS);
    ps2d_oe_s = (state_s == START) || ((state_s == DATA) && !frame_s[bit_idx_s]);
    busy_s    = (state_s != IDLE);
  end

  // State, frame and registered outputs; reset releases both lines at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      frame_r   <= 9'd0;
      bit_idx_r <= 4'd0;
      rts_cnt_r <= 32'd0;
      ps2c_oe_r <= 1'b0;
      ps2d_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      frame_r   <= frame_s;
      bit_idx_r <= bit_idx_s;
      rts_cnt_r <= rts_cnt_s;
      ps2c_oe_r <= ps2c_oe_s;
      ps2d_oe_r <= ps2d_oe_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

`ifdef PS2_TX_WATCHDOG_EN
  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= 32'd0;
    end else begin
      wd_cnt_r <= wd_cnt_s;
    end
  end
`endif

  assign ps2c_oe      = ps2c_oe_r;
  assign ps2d_oe      = ps2d_oe_r;
  assign tx_busy      = busy_r;
  assign tx_done_tick = done_r;
  assign tx_err_tick  = err_r;

endmodule

// File: tb/tb_ps2_mouse_tx.sv
// Scoreboard bench for ps2_mouse_tx: a device model clocks the frame and
// records the bits it sees; expected frames/outcomes are queued at issue
// time and a monitor pops and compares on every done/error tick.
module tb_ps2_mouse_tx;

  localparam int RTS        = 5000;
  localparam int FLEN       = 8;
  localparam int TB_TIMEOUT = 4000;
  localparam int HALF       = 20;

  typedef struct {
    bit          is_err;
    bit          check_frame;
    logic [10:0] frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err_tick;

  logic [10:0] dev_frame;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  bit          started = 1'b0;
  bit          prev_c = 1'b0;
  bit          prev_d = 1'b0;
  int          c_run = 0;

  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  ps2_mouse_tx #(
    .RTS_CYCLES     (RTS),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_in),
    .ps2d_in      (ps2d_in),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wire order seen by the device: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = (d >> i) & 8'd1;
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (tx_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, tx_busy, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Device model: waits for the start bit, then generates clock falls and
  // samples the data line late in each low phase.
  task automatic run_device(input bit ack_low, input int glitch_f, input int wr_f,
                            input int rst_f, input int stall_f);
    int n = 0;
    dev_frame = 11'h7FF;
    while (!(ps2d_oe && !ps2c_oe) && n < RTS + 100) begin
      @(negedge clk);
      n++;
    end
    chk("start_wait", {31'd0, ps2d_oe && !ps2c_oe}, 1);
    if (!(ps2d_oe && !ps2c_oe)) return;
    repeat (HALF) @(negedge clk);
    for (int f = 1; f <= 12; f++) begin
      if (f == stall_f) return;
      if (f == 1) dev_frame[0] = ps2d_in;
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (f <= 10) dev_frame[f] = ps2d_in;
      if (f == 10) dev_d_low = ack_low;
      if (f == rst_f) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_c_oe", ps2c_oe, 0);
        chk("rst_d_oe", ps2d_oe, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ticks", {tx_done_tick, tx_err_tick}, 0);
        rst = 1'b0;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        return;
      end
      dev_c_low = 1'b0;
      if (f == glitch_f) begin
        repeat (HALF / 2) @(negedge clk);
        dev_c_low = 1'b1;
        @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HALF - HALF / 2 - 1) @(negedge clk);
      end else if (f == wr_f) begin
        repeat (HALF / 2) @(negedge clk);
        din = 8'h00;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        repeat (HALF - HALF / 2 - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_d_low = 1'b0;
  endtask

  task automatic do_txn(input logic [7:0] d, input bit ack_low, input int glitch_f,
                        input int wr_f, input int rst_f, input int stall_f);
    exp_t e;
    bit   completes;
    completes = (rst_f == 0) && (stall_f == 0);
    if (completes) begin
      e.is_err      = !ack_low;
      e.check_frame = 1'b1;
      e.frame       = model_frame(d);
      exp_q.push_back(e);
    end
    @(negedge clk);
    din = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    run_device(ack_low, glitch_f, wr_f, rst_f, stall_f);
    if (completes) begin
      wait_idle(2000, "end_wait");
      repeat (20) @(negedge clk);
      chk("busy_after", tx_busy, 0);
    end else begin
      repeat (20) @(negedge clk);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard compare on every tick.
  always @(negedge clk) begin
    if (started) begin
      chk("oe_overlap", {31'd0, ps2c_oe & ps2d_oe}, 0);
      if (ps2d_oe && !prev_d && prev_c) chk("rts_len", c_run, RTS);
      if (ps2c_oe) c_run = prev_c ? c_run + 1 : 1;
      if (ps2c_oe && !prev_c) chk("busy_with_rts", tx_busy, 1);
      prev_c = ps2c_oe;
      prev_d = ps2d_oe;
      if (tx_done_tick || tx_err_tick) begin
        chk("tick_excl", {31'd0, tx_done_tick & tx_err_tick}, 0);
        chk("busy_at_tick", tx_busy, 0);
        chk("oe_at_tick", {ps2c_oe, ps2d_oe}, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: done=%0b err=%0b with nothing expected at %0t",
                   tx_done_tick, tx_err_tick, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("outcome_err", tx_err_tick, mon_e.is_err);
          chk("outcome_done", tx_done_tick, !mon_e.is_err);
          if (mon_e.check_frame) chk("frame", dev_frame, mon_e.frame);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t required earlier", $time);
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("reset_c_oe", ps2c_oe, 0);
    chk("reset_d_oe", ps2d_oe, 0);
    chk("reset_busy", tx_busy, 0);
    chk("reset_done", tx_done_tick, 0);
    chk("reset_err", tx_err_tick, 0);
    rst = 1'b0;
    started = 1'b1;
    repeat (5) @(negedge clk);

    do_txn(8'hF4, 1'b1, 0, 0, 0, 0);           // nominal command
    do_txn(8'hFF, 1'b1, 0, 0, 0, 0);           // parity bit 1
    do_txn(8'($urandom_range(255)), 1'b0, 0, 0, 0, 0);  // missing ack
    do_txn(8'hF4, 1'b1, 0, 4, 0, 0);           // wr_ps2 ignored mid-frame
    do_txn(8'($urandom_range(255)), 1'b1, 3, 0, 0, 0);  // clock glitch
    do_txn(8'hA5, 1'b1, 0, 0, 5, 0);           // reset mid-DATA
    for (int i = 0; i < 3; i++) begin
      do_txn(8'($urandom_range(255)), ($urandom_range(3) != 0), 0, 0, 0, 0);
    end

    // Device stops clocking after bit 3.
`ifdef PS2_TX_WATCHDOG_EN
    e.is_err      = 1'b1;
    e.check_frame = 1'b0;
    e.frame       = 11'd0;
    exp_q.push_back(e);
    do_txn(8'h3C, 1'b1, 0, 0, 0, 5);
    wait_idle(TB_TIMEOUT + 1000, "watchdog_wait");
    repeat (20) @(negedge clk);
`else
    begin
      int idle_seen = 0;
      do_txn(8'h3C, 1'b1, 0, 0, 0, 5);
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (!tx_busy) idle_seen++;
      end
      chk("stall_busy_held", idle_seen, 0);
      reset_pulse();
      repeat (5) @(negedge clk);
      chk("stall_reset_busy", tx_busy, 0);
    end
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
